// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS control unit:
// opcodes, functs, ALU ops, FSM states and datapath selects.
package mc_pkg;

    localparam int ALU_OP_W = 4;
    localparam int ST_W     = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_LUI = 4'd5;

    typedef enum logic [ST_W-1:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU,
        S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH,
        S_JUMP, S_TRAP
    } state_e;

    typedef enum logic [3:0] {
        C_NOP, C_RTYPE, C_ITYPE, C_LW, C_SW,
        C_BEQ, C_J, C_JAL, C_JR, C_ILL
    } cls_e;

    localparam logic [1:0] PC_ALU = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;
    localparam logic [1:0] PC_RS  = 2'd3;

    localparam logic [1:0] WSEL_RT = 2'd0;
    localparam logic [1:0] WSEL_RD = 2'd1;
    localparam logic [1:0] WSEL_RA = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;

    localparam logic [1:0] SRC2_RT  = 2'd0;
    localparam logic [1:0] SRC2_4   = 2'd1;
    localparam logic [1:0] SRC2_IMM = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: class, ALU op, imm extension
// and register write select for the control FSM.
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] ir,
    output cls_e        cls,
    output logic [3:0]  alu_op,
    output logic        ext_op,
    output logic [1:0]  rf_wsel
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       rt;

    assign op = ir[31:26];
    assign fn = ir[5:0];
    assign rt = (op == OP_RTYPE);

    always_comb begin
        cls     = C_ILL;
        alu_op  = ALU_ADD;
        ext_op  = 1'b0;
        rf_wsel = WSEL_RT;
        // ir==0 has funct 0, so it cannot overlap any R-type arm
        unique case (1'b1)
            (ir == 32'd0):            cls = C_NOP;
            (rt && fn == F_ADDU): begin
                cls = C_RTYPE; alu_op = ALU_ADD; rf_wsel = WSEL_RD;
            end
            (rt && fn == F_SUBU): begin
                cls = C_RTYPE; alu_op = ALU_SUB; rf_wsel = WSEL_RD;
            end
            (rt && fn == F_AND): begin
                cls = C_RTYPE; alu_op = ALU_AND; rf_wsel = WSEL_RD;
            end
            (rt && fn == F_OR): begin
                cls = C_RTYPE; alu_op = ALU_OR; rf_wsel = WSEL_RD;
            end
            (rt && fn == F_XOR): begin
                cls = C_RTYPE; alu_op = ALU_XOR; rf_wsel = WSEL_RD;
            end
            (rt && fn == F_JR):       cls = C_JR;
            (op == OP_ORI): begin
                cls = C_ITYPE; alu_op = ALU_OR;
            end
            (op == OP_ADDIU): begin
                cls = C_ITYPE; alu_op = ALU_ADD; ext_op = 1'b1;
            end
            (op == OP_LUI): begin
                cls = C_ITYPE; alu_op = ALU_LUI;
            end
            (op == OP_LW): begin
                cls = C_LW; ext_op = 1'b1;
            end
            (op == OP_SW): begin
                cls = C_SW; ext_op = 1'b1;
            end
            (op == OP_BEQ): begin
                cls = C_BEQ; alu_op = ALU_SUB;
            end
            (op == OP_J):             cls = C_J;
            (op == OP_JAL):           cls = C_JAL;
            default:                  cls = C_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM driving the datapath strobes and ALU op.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap on undecodable instructions.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        rf_we,
    output logic [1:0]  rf_wsel,
    output logic [1:0]  rf_wdsel,
    output logic        alu_src1,
    output logic [1:0]  alu_src2,
    output logic        ext_op,
    output logic [3:0]  alu_op,
    output logic [3:0]  state,
    output logic        illegal
);

    state_e     st, nxt;
    cls_e       d_cls;
    logic [3:0] d_op;
    logic       d_ext;
    logic [1:0] d_wsel;

    mc_decode u_dec (
        .ir      (ir),
        .cls     (d_cls),
        .alu_op  (d_op),
        .ext_op  (d_ext),
        .rf_wsel (d_wsel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= S_RST;
        else        st <= nxt;
    end

    assign state = st;

    always_comb begin
        nxt      = st;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = PC_ALU;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        rf_we    = 1'b0;
        rf_wsel  = WSEL_RT;
        rf_wdsel = WD_ALU;
        alu_src1 = 1'b0;
        alu_src2 = SRC2_RT;
        ext_op   = 1'b0;
        alu_op   = ALU_ADD;
        illegal  = 1'b0;
        unique case (st)
            S_RST: nxt = S_FETCH;
            S_FETCH: begin
                mem_rd   = 1'b1;
                alu_src1 = 1'b1;
                alu_src2 = SRC2_4;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                    nxt   = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (d_cls)
                    C_RTYPE:     nxt = S_EXEC_R;
                    C_ITYPE:     nxt = S_EXEC_I;
                    C_LW, C_SW:  nxt = S_MEM_ADDR;
                    C_BEQ:       nxt = S_BRANCH;
                    C_J, C_JAL,
                    C_JR:        nxt = S_JUMP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    C_ILL:       nxt = S_TRAP;
`endif
                    default:     nxt = S_FETCH;
                endcase
            end
            S_EXEC_R: begin
                alu_op = d_op;
                nxt    = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src2 = SRC2_IMM;
                ext_op   = d_ext;
                alu_op   = d_op;
                nxt      = S_WB_ALU;
            end
            S_WB_ALU: begin
                // keep the EXEC operands steering the ALU result being written
                rf_we    = 1'b1;
                rf_wsel  = d_wsel;
                alu_src2 = (d_cls == C_RTYPE) ? SRC2_RT : SRC2_IMM;
                ext_op   = d_ext;
                alu_op   = d_op;
                nxt      = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src2 = SRC2_IMM;
                ext_op   = 1'b1;
                nxt      = (d_cls == C_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_rd   = 1'b1;
                alu_src2 = SRC2_IMM;
                ext_op   = 1'b1;
                if (mem_ready) nxt = S_WB_MEM;
            end
            S_WB_MEM: begin
                rf_we    = 1'b1;
                rf_wdsel = WD_MEM;
                nxt      = S_FETCH;
            end
            S_MEM_WR: begin
                mem_wr = 1'b1;
                if (mem_ready) nxt = S_FETCH;
            end
            S_BRANCH: begin
                alu_op = ALU_SUB;
                pc_src = PC_BR;
                pc_we  = zero;
                nxt    = S_FETCH;
            end
            S_JUMP: begin
                pc_we  = 1'b1;
                pc_src = (d_cls == C_JR) ? PC_RS : PC_JMP;
                if (d_cls == C_JAL) begin
                    rf_we    = 1'b1;
                    rf_wsel  = WSEL_RA;
                    rf_wdsel = WD_PC;
                end
                nxt = S_FETCH;
            end
            S_TRAP: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                illegal = 1'b1;
                nxt     = S_TRAP;
`else
                nxt     = S_FETCH;
`endif
            end
            default: nxt = S_RST;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed vector bench for mc_ctrl: per-cycle state/output table
// plus hand sequences for async reset and illegal-opcode handling.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ir;
    logic        zero;
    logic        mem_ready;
    logic        ir_we, pc_we, mem_rd, mem_wr, rf_we;
    logic        alu_src1, ext_op, illegal;
    logic [1:0]  pc_src, rf_wsel, rf_wdsel, alu_src2;
    logic [3:0]  alu_op, state;

    mc_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir        (ir),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .rf_we     (rf_we),
        .rf_wsel   (rf_wsel),
        .rf_wdsel  (rf_wdsel),
        .alu_src1  (alu_src1),
        .alu_src2  (alu_src2),
        .ext_op    (ext_op),
        .alu_op    (alu_op),
        .state     (state),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] RST = 0, FET = 1, DEC = 2, EXR = 3, EXI = 4;
    localparam logic [3:0] WBA = 5, MAD = 6, MRD = 7, WBM = 8, MWR = 9;
    localparam logic [3:0] BRA = 10, JMP = 11, TRP = 12;

    localparam logic [31:0] I_ADDU = 32'h0022_1821;
    localparam logic [31:0] I_LW   = 32'h8C22_0004;
    localparam logic [31:0] I_BEQ  = 32'h1022_0003;
    localparam logic [31:0] I_JAL  = 32'h0C00_0010;
    localparam logic [31:0] I_LUI  = 32'h3C01_1234;
    localparam logic [31:0] I_ORI  = 32'h3421_00FF;
    localparam logic [31:0] I_JR   = 32'h03E0_0008;
    localparam logic [31:0] I_SW   = 32'hAC22_0008;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;

    typedef struct packed {
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       mem_rd;
        logic       mem_wr;
        logic       rf_we;
        logic [1:0] rf_wsel;
        logic [1:0] rf_wdsel;
        logic       alu_src1;
        logic [1:0] alu_src2;
        logic       ext_op;
        logic [3:0] alu_op;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic        rst_n;
        logic [31:0] ir;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        outs_t       o;
    } vec_t;

    vec_t  vq[$];
    int    compared = 0;
    int    mismatched = 0;
    outs_t Z, FR, FW;

    function automatic outs_t mk(
        input logic iw, pw, input logic [1:0] ps,
        input logic mr, mw, rw, input logic [1:0] ws, wd,
        input logic s1, input logic [1:0] s2,
        input logic ex, input logic [3:0] op);
        outs_t o;
        o = '{iw, pw, ps, mr, mw, rw, ws, wd, s1, s2, ex, op, 1'b0};
        return o;
    endfunction

    function automatic outs_t actual();
        outs_t o;
        o = '{ir_we, pc_we, pc_src, mem_rd, mem_wr, rf_we, rf_wsel,
              rf_wdsel, alu_src1, alu_src2, ext_op, alu_op, illegal};
        return o;
    endfunction

    task automatic add(input logic [31:0] i, input logic z, r,
                       input logic [3:0] s, input outs_t o);
        vec_t v;
        v = '{1'b1, i, z, r, s, o};
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] i,
                         input logic z, input logic m);
        @(posedge clk);
        #1;
        rst_n = r; ir = i; zero = z; mem_ready = m;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ir = '0; zero = 1'b0; mem_ready = 1'b0;
        Z  = '0;
        FR = mk(1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        FW = mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);

        add(I_ADDU, 0, 0, RST, Z);
        add(I_ADDU, 0, 1, FET, FR);
        add(I_ADDU, 0, 1, DEC, Z);
        add(I_ADDU, 0, 1, EXR, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(I_ADDU, 0, 1, WBA, mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        add(I_LW,   0, 0, FET, FW);
        add(I_LW,   0, 1, FET, FR);
        add(I_LW,   0, 1, DEC, Z);
        add(I_LW,   0, 1, MAD, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0));
        for (int k = 0; k < 3; k++)
            add(I_LW, 0, 0, MRD, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 1, 0));
        add(I_LW,   0, 1, MRD, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 1, 0));
        add(I_LW,   0, 1, WBM, mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        add(I_BEQ,  1, 1, FET, FR);
        add(I_BEQ,  1, 1, DEC, Z);
        add(I_BEQ,  1, 1, BRA, mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        add(I_BEQ,  0, 1, FET, FR);
        add(I_BEQ,  0, 1, DEC, Z);
        add(I_BEQ,  0, 1, BRA, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        add(I_JAL,  0, 1, FET, FR);
        add(I_JAL,  0, 1, DEC, Z);
        add(I_JAL,  0, 1, JMP, mk(0, 1, 2, 0, 0, 1, 2, 2, 0, 0, 0, 0));
        add(I_LUI,  0, 1, FET, FR);
        add(I_LUI,  0, 1, DEC, Z);
        add(I_LUI,  0, 1, EXI, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 5));
        add(I_LUI,  0, 1, WBA, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 5));
        add(I_ORI,  0, 1, FET, FR);
        add(I_ORI,  0, 1, DEC, Z);
        add(I_ORI,  0, 1, EXI, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 3));
        add(I_ORI,  0, 1, WBA, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 3));
        add(I_JR,   0, 1, FET, FR);
        add(I_JR,   0, 1, DEC, Z);
        add(I_JR,   0, 1, JMP, mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(32'h0,  0, 1, FET, FR);
        add(32'h0,  0, 1, DEC, Z);
        add(32'h0,  0, 0, FET, FW);
        add(I_SW,   0, 1, FET, FR);
        add(I_SW,   0, 1, DEC, Z);
        add(I_SW,   0, 1, MAD, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0));
        add(I_SW,   0, 0, MWR, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        add(I_SW,   0, 1, MWR, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        add(I_SW,   0, 0, FET, FW);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", int'(state), int'(RST));
        chk("reset_outs", int'(actual()), 0);

        foreach (vq[i]) begin
            drive(vq[i].rst_n, vq[i].ir, vq[i].zero, vq[i].rdy);
            chk($sformatf("row%0d_state", i), int'(state), int'(vq[i].st));
            chk($sformatf("row%0d_outs", i), int'(actual()), int'(vq[i].o));
        end

        drive(1, I_BAD, 0, 1);
        chk("bad_fetch", int'(state), int'(FET));
        drive(1, I_BAD, 0, 1);
        chk("bad_decode", int'(state), int'(DEC));
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        for (int k = 0; k < 3; k++) begin
            drive(1, I_BAD, 0, 1);
            chk($sformatf("trap_state%0d", k), int'(state), int'(TRP));
            chk($sformatf("trap_illegal%0d", k), int'(illegal), 1);
            chk($sformatf("trap_strobes%0d", k),
                int'({ir_we, pc_we, mem_rd, mem_wr, rf_we}), 0);
        end
`else
        drive(1, I_BAD, 0, 1);
        chk("bad_nop_state", int'(state), int'(FET));
        chk("bad_nop_illegal", int'(illegal), 0);
`endif

        drive(0, I_SW, 0, 1);
        chk("rst2_state", int'(state), int'(RST));
        drive(1, I_SW, 0, 1);
        chk("rst2_hold", int'(state), int'(RST));
        drive(1, I_SW, 0, 1);
        chk("rst2_fetch", int'(state), int'(FET));
        drive(1, I_SW, 0, 1);
        drive(1, I_SW, 0, 1);
        drive(1, I_SW, 0, 0);
        chk("mwr_state", int'(state), int'(MWR));
        chk("mwr_strobe", int'(mem_wr), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mem_wr", int'(mem_wr), 0);
        chk("async_state", int'(state), int'(RST));
        drive(1, I_SW, 0, 0);
        chk("release_state", int'(state), int'(RST));
        drive(1, I_SW, 0, 0);
        chk("release_fetch", int'(state), int'(FET));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
